rf_multiport: RTL and testbench
===============================

Name: rf_multiport

Overview:
Parametrised integer register file for the RISC-V core, replacing the fixed 32x32 two-read file.
- Configurable data width, register count and read-port count.
- Register 0 optionally hardwired to zero.
- Per-register pending-write scoreboard for long-latency (load) results.
- Multi-cycle software-initiated clear sequencer.
- Sits between decode (reads, scoreboard set) and writeback (write, scoreboard clear).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of registers; power of two, 2..64
AW, 5, address width; must equal log2(NREGS)
NRD, 2, number of read ports, 1..4
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes/sets; 0 = register 0 is an ordinary register

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
rd_addr  in  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW]
rd_data  out  NRD*XLEN  packed read data; port i uses bits [i*XLEN +: XLEN]
rd_pend  out  NRD  port i: scoreboard bit of rd_addr[i]
wr_en  in  1  write enable
wr_addr  in  AW  write address
wr_data  in  XLEN  write data
sb_set_en  in  1  mark register pending (load issued)
sb_set_addr  in  AW  register to mark pending
clr_req  in  1  start clear sequence (single-cycle pulse or level)
busy  out  1  clear sequence in progress
wr_drop  out  1  one-cycle pulse: a write or set was discarded because busy

Behaviour:
- Reset (rst=1, asynchronous): all registers = 0, all scoreboard bits = 0, FSM = IDLE, clear pointer = 0, busy = 0, wr_drop = 0.
- Reads:
  - Purely combinational: rd_data[i] = reg[rd_addr[i]]; rd_pend[i] = sb[rd_addr[i]].
  - All ports are independent; any number of ports may read the same address.
  - ZERO_REG=1 and address 0: rd_data = 0 and rd_pend = 0.
- Writes (IDLE only):
  - On a clk edge with wr_en=1: reg[wr_addr] <= wr_data and sb[wr_addr] <= 0.
  - Read-after-write in the same cycle returns the old value (see Optional Feature).
- Scoreboard set (IDLE only): sb_set_en=1 sets sb[sb_set_addr] <= 1.
- Simultaneous write and set to the same address: data is written and the set wins (sb = 1). This is a new load issued behind an older writeback.
- ZERO_REG=1: writes and sets to address 0 are ignored and do not pulse wr_drop.
- FSM IDLE:
  - clr_req=1 moves to CLEAR on the next edge and clears the pointer to 0.
  - busy asserts in the cycle after clr_req is sampled.
  - Writes and sets in the same cycle as clr_req are still performed.
- FSM CLEAR:
  - Each cycle: reg[ptr] <= 0, sb[ptr] <= 0, ptr <= ptr+1.
  - When ptr == NREGS-1, that register is cleared, ptr wraps to 0 and the FSM returns to IDLE. busy = 1 for exactly NREGS cycles.
  - wr_en or sb_set_en during CLEAR: request discarded; wr_drop = 1 on the following cycle for one cycle.
  - clr_req during CLEAR is ignored; the sequence is not restarted.
  - Reads remain live: a cleared register reads 0, a not-yet-cleared register reads its old value.
- Reset mid-CLEAR aborts immediately to the reset state.
- Width rules:
  - wr_data is stored unmodified.
  - The pointer is AW bits wide and wraps naturally.
  - AW != log2(NREGS) is a configuration error; the implementation emits a $error in an initial block.

Optional Feature:
Macro RF_WR_BYPASS_EN.
- Defined (write-through bypass):
  - In IDLE, if wr_en=1 and rd_addr[i]==wr_addr (excluding address 0 when ZERO_REG=1), then rd_data[i] = wr_data in the same cycle.
  - In that case rd_pend[i] = 0, unless sb_set_en targets the same address that cycle, in which case rd_pend[i] = 1.
  - Bypass is disabled while busy.
- Undefined: no bypass; a same-cycle read returns the pre-write value and pre-write pending bit, exactly as in Behaviour.

Test Plan:
1. Reset, then write x5=0xDEADBEEF, x6=0x12345678. Read port0=5, port1=6 next cycle -> 0xDEADBEEF, 0x12345678, rd_pend=00.
2. ZERO_REG=1: write x0=0xFFFFFFFF and sb_set x0 -> rd_data=0 and rd_pend=0 on port reading x0, wr_drop=0. With ZERO_REG=0, x0 reads 0xFFFFFFFF.
3. Scoreboard:
   - sb_set x7 -> rd_pend=1 next cycle.
   - Write x7=0x55 -> rd_pend=0 and data 0x55.
   - Same-cycle write x7 and sb_set x7 -> data 0x55 and rd_pend=1.
4. Load x1..x31 with 0x100+i, pulse clr_req -> busy high exactly 32 cycles. Reading x31 during clear returns 0x11F until the final busy cycle, then 0. All registers and pend bits read 0 afterwards.
5. wr_en x3=0xAA at clear cycle 4 -> wr_drop pulses once next cycle and x3 reads 0 after clear. clr_req repeated at cycle 10 -> busy still drops at cycle 32.
6. RF_WR_BYPASS_EN:
   - Write x9=0xCAFE while port1 reads x9 in the same cycle -> rd_data=0xCAFE combinationally.
   - Without the macro -> old value, then 0xCAFE next cycle.
   - Assert rst at clear cycle 8 -> busy=0 and all registers read 0 immediately.

Source files
------------

// File: rtl/rf_multiport.sv
// Parametrised integer register file with pending-write scoreboard and a multi-cycle clear sequencer.
// Optional same-cycle write-through bypass on reads: define RF_WR_BYPASS_EN.
module rf_multiport #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pend,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                sb_set_en,
  input  logic [AW-1:0]       sb_set_addr,
  input  logic                clr_req,
  output logic                busy,
  output logic                wr_drop
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  localparam logic [AW-1:0] LAST_PTR = AW'(NREGS - 1);
  localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};

  generate
    if (AW != $clog2(NREGS)) begin : g_cfg_err
      initial $error("rf_multiport: AW (%0d) must equal log2(NREGS) (%0d)", AW, $clog2(NREGS));
    end
  endgenerate

  state_e              state_q;
  logic [AW-1:0]       ptr_q;
  logic                busy_q;
  logic                wr_drop_q;
  logic [XLEN-1:0]     regs_q [NREGS];
  logic [NREGS-1:0]    sb_q;

  logic                wr_nz_s;
  logic                set_nz_s;
  logic                wr_ok_s;
  logic                set_ok_s;
  logic                req_drop_s;
  logic [AW-1:0]       rd_idx_s [NRD];

  // Qualify write/set requests: register 0 is invisible when hardwired, and only IDLE may update.
  always_comb begin
    wr_nz_s    = wr_en     && !((ZERO_REG != 0) && (wr_addr     == ZERO_ADDR));
    set_nz_s   = sb_set_en && !((ZERO_REG != 0) && (sb_set_addr == ZERO_ADDR));
    wr_ok_s    = wr_nz_s  && (state_q == S_IDLE);
    set_ok_s   = set_nz_s && (state_q == S_IDLE);
    req_drop_s = (state_q == S_CLEAR) && (wr_nz_s || set_nz_s);
  end

  // Clear sequencer: walks the pointer over every register once, then returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= {AW{1'b0}};
      busy_q    <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= req_drop_s;
      case (state_q)
        S_IDLE: begin
          if (clr_req) begin
            state_q <= S_CLEAR;
            ptr_q   <= {AW{1'b0}};
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        S_CLEAR: begin
          ptr_q <= ptr_q + AW'(1);
          if (ptr_q == LAST_PTR) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Register and scoreboard storage; a set beats a same-cycle write so a newer load stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= {XLEN{1'b0}};
        sb_q[r]   <= 1'b0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if ((state_q == S_CLEAR) && (ptr_q == AW'(r))) begin
          regs_q[r] <= {XLEN{1'b0}};
          sb_q[r]   <= 1'b0;
        end else begin
          if (wr_ok_s && (wr_addr == AW'(r))) begin
            regs_q[r] <= wr_data;
          end else begin
            regs_q[r] <= regs_q[r];
          end
          if (set_ok_s && (sb_set_addr == AW'(r))) begin
            sb_q[r] <= 1'b1;
          end else if (wr_ok_s && (wr_addr == AW'(r))) begin
            sb_q[r] <= 1'b0;
          end else begin
            sb_q[r] <= sb_q[r];
          end
        end
      end
    end
  end

  // Combinational read ports, each fully independent.
  always_comb begin
    rd_data = {(NRD*XLEN){1'b0}};
    rd_pend = {NRD{1'b0}};
    for (int i = 0; i < NRD; i++) begin
      rd_idx_s[i] = rd_addr[i*AW +: AW];
      if ((ZERO_REG != 0) && (rd_idx_s[i] == ZERO_ADDR)) begin
        rd_data[i*XLEN +: XLEN] = {XLEN{1'b0}};
        rd_pend[i]              = 1'b0;
      end
`ifdef RF_WR_BYPASS_EN
      else if (wr_ok_s && (rd_idx_s[i] == wr_addr)) begin
        rd_data[i*XLEN +: XLEN] = wr_data;
        rd_pend[i]              = set_ok_s && (sb_set_addr == wr_addr);
      end
`endif
      else begin
        rd_data[i*XLEN +: XLEN] = regs_q[rd_idx_s[i]];
        rd_pend[i]              = sb_q[rd_idx_s[i]];
      end
    end
  end

  assign busy    = busy_q;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_rf_multiport.sv
// Directed self-checking bench for rf_multiport (default parameters, ZERO_REG=1).
module tb_rf_multiport;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pend;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        sb_set_en;
  logic [4:0]  sb_set_addr;
  logic        clr_req;
  logic        busy;
  logic        wr_drop;

  int checks;
  int failures;

  rf_multiport dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .clr_req(clr_req), .busy(busy), .wr_drop(wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr[4:0] = a0;
    rd_addr[9:5] = a1;
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; rd_addr = 10'd0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    sb_set_en = 1'b0; sb_set_addr = 5'd0; clr_req = 1'b0;
    tick(); tick();
    rd(5'd5, 5'd6);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_drop", {31'd0, wr_drop}, 32'd0);
    chk("rst_x5", rd_data[31:0], 32'd0);
    chk("rst_pend", {30'd0, rd_pend}, 32'd0);
    rst = 1'b0;
    tick();

    // basic writes
    wr(5'd5, 32'hDEADBEEF);
    wr(5'd6, 32'h12345678);
    rd(5'd5, 5'd6);
    chk("x5", rd_data[31:0], 32'hDEADBEEF);
    chk("x6", rd_data[63:32], 32'h12345678);
    chk("pend56", {30'd0, rd_pend}, 32'd0);

    // hardwired x0
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    sb_set_en = 1'b1; sb_set_addr = 5'd0;
    tick();
    wr_en = 1'b0; sb_set_en = 1'b0;
    rd(5'd0, 5'd5);
    chk("x0_data", rd_data[31:0], 32'd0);
    chk("x0_pend", {31'd0, rd_pend[0]}, 32'd0);
    chk("x0_drop", {31'd0, wr_drop}, 32'd0);

    // scoreboard
    sb_set_en = 1'b1; sb_set_addr = 5'd7;
    tick();
    sb_set_en = 1'b0;
    rd(5'd7, 5'd6);
    chk("sb7_set", {31'd0, rd_pend[0]}, 32'd1);
    wr(5'd7, 32'h55);
    rd(5'd7, 5'd6);
    chk("sb7_wr_pend", {31'd0, rd_pend[0]}, 32'd0);
    chk("sb7_wr_data", rd_data[31:0], 32'h55);
    sb_set_en = 1'b1; sb_set_addr = 5'd7;
    wr(5'd7, 32'h55);
    sb_set_en = 1'b0;
    rd(5'd7, 5'd6);
    chk("sb7_both_data", rd_data[31:0], 32'h55);
    chk("sb7_both_pend", {31'd0, rd_pend[0]}, 32'd1);

    // same-cycle read of a write in flight
    rd(5'd7, 5'd9);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFE;
    #1;
`ifdef RF_WR_BYPASS_EN
    chk("byp_same", rd_data[63:32], 32'hCAFE);
`else
    chk("byp_same", rd_data[63:32], 32'h0);
`endif
    tick();
    wr_en = 1'b0;
    #1;
    chk("byp_next", rd_data[63:32], 32'hCAFE);

    // load x1..x31 then clear
    for (int i = 1; i < 32; i++) wr(5'(i), 32'h100 + 32'(i));
    rd(5'd4, 5'd31);
    chk("pre_x31", rd_data[63:32], 32'h11F);
    chk("pre_x4", rd_data[31:0], 32'h104);
    chk("pre_pend7", {31'd0, dut.sb_q[7]}, 32'd0);
    clr_req = 1'b1; sb_set_en = 1'b1; sb_set_addr = 5'd4;
    tick();
    clr_req = 1'b0; sb_set_en = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      chk($sformatf("busy_k%0d", k), {31'd0, busy}, {31'd0, (k < 32)});
      chk($sformatf("drop_k%0d", k), {31'd0, wr_drop}, {31'd0, (k == 4)});
      chk($sformatf("x31_k%0d", k), rd_data[63:32], (k < 32) ? 32'h11F : 32'h0);
      chk($sformatf("x4pend_k%0d", k), {31'd0, rd_pend[0]}, {31'd0, (k < 5)});
      wr_en = (k == 3); wr_addr = 5'd3; wr_data = 32'hAA;
      clr_req = (k == 9);
      if (k < 32) tick();
    end
    wr_en = 1'b0; clr_req = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'd3);
      chk($sformatf("post_x%0d", a), rd_data[31:0], 32'h0);
      chk($sformatf("post_p%0d", a), {31'd0, rd_pend[0]}, 32'h0);
    end

    // reset during clear
    wr(5'd20, 32'h2020);
    rd(5'd4, 5'd20);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (8) tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("mid_x20", rd_data[63:32], 32'h2020);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_x20", rd_data[63:32], 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("after_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
